control_fsm: RTL and testbench

CONTROL_FSM -- requirements
Module: control_fsm

---
 rtl/control_fsm_if.sv | 46 ++++
 rtl/control_fsm.sv | 150 +++++++++++++++
 tb/tb_control_fsm.sv | 203 ++++++++++++++++++++
 3 files changed

// File: rtl/control_fsm_if.sv
// control_fsm_if
// Bundles the control FSM's datapath-facing signals.
//   master : the control FSM (consumes ce/instr_in/carry, drives the control strobes)
//   slave  : the datapath / memory side (drives ce/instr_in/carry, consumes the strobes)
// Signals:
//   ce         clock enable
//   instr_in   memory read data, [7:6] opcode, [5:0] address field
//   carry      current carry flag
//   ir_addr    IR address field (PC ADR_IN and memory address mux)
//   sel_ADR    memory address select, 0 = PC, 1 = ir_addr
//   mem_en     memory access strobe
//   mem_we     memory write strobe
//   load_PC, enable_PC, clear_PC   program counter controls
//   load_RA    accumulator load
//   sel_UAL    ALU op, 0 = NOR, 1 = ADD
//   load_carry, init_carry         carry flag update / clear
//   state_dbg  current state encoding
interface control_fsm_if;
   logic       ce;
   logic [7:0] instr_in;
   logic       carry;
   logic [5:0] ir_addr;
   logic       sel_ADR;
   logic       mem_en;
   logic       mem_we;
   logic       load_PC;
   logic       enable_PC;
   logic       clear_PC;
   logic       load_RA;
   logic       sel_UAL;
   logic       load_carry;
   logic       init_carry;
   logic [2:0] state_dbg;

   modport master (
      input  ce, instr_in, carry,
      output ir_addr, sel_ADR, mem_en, mem_we, load_PC, enable_PC, clear_PC,
             load_RA, sel_UAL, load_carry, init_carry, state_dbg
   );

   modport slave (
      output ce, instr_in, carry,
      input  ir_addr, sel_ADR, mem_en, mem_we, load_PC, enable_PC, clear_PC,
             load_RA, sel_UAL, load_carry, init_carry, state_dbg
   );
endinterface

// File: rtl/control_fsm.sv
// control_fsm
// Sequencer for a 4-instruction accumulator CPU (NOR, ADD, STA, JCC).
// Ports:
//   clk  system clock, all state changes on the rising edge
//   rst  synchronous active-high reset (state -> INIT, IR -> 0)
//   bus  control_fsm_if.master: ce, instr_in, carry in; control strobes,
//        ir_addr and state_dbg out
// Outputs are decoded from state, IR, carry (JUMP only), ce and rst; instr_in
// only ever reaches the next-state/IR logic, never an output.
module control_fsm (
   input  logic          clk,
   input  logic          rst,
   control_fsm_if.master bus
);

   typedef enum logic [2:0] {
      ST_INIT    = 3'd0,
      ST_FETCH   = 3'd1,
      ST_DECODE  = 3'd2,
      ST_OPERAND = 3'd3,
      ST_EXEC    = 3'd4,
      ST_STORE   = 3'd5,
      ST_JUMP    = 3'd6,
      ST_ILLEGAL = 3'd7
   } state_e;

   state_e     state_q, state_d;
   logic [7:0] ir_q, ir_d;

   logic sel_adr_s, mem_en_s, mem_we_s, load_pc_s, enable_pc_s, clear_pc_s;
   logic load_ra_s, sel_ual_s, load_carry_s, init_carry_s;
   logic strobe_ok_s;

   // State and instruction register, synchronous reset wins over ce
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_INIT;
         ir_q    <= 8'h00;
      end else begin
         state_q <= state_d;
         ir_q    <= ir_d;
      end
   end

   // Next-state and IR capture; everything holds while ce is low
   always_comb begin
      state_d = state_q;
      ir_d    = ir_q;
      if (bus.ce) begin
         case (state_q)
            ST_INIT:    state_d = ST_FETCH;
            ST_FETCH:   state_d = ST_DECODE;
            ST_DECODE: begin
               // Branch on the word being latched, not the old IR
               ir_d = bus.instr_in;
               case (bus.instr_in[7:6])
                  2'b00, 2'b01: state_d = ST_OPERAND;
                  2'b10:        state_d = ST_STORE;
                  2'b11:        state_d = ST_JUMP;
                  default:      state_d = ST_INIT;
               endcase
            end
            ST_OPERAND: state_d = ST_EXEC;
            ST_EXEC:    state_d = ST_FETCH;
            ST_STORE:   state_d = ST_FETCH;
            ST_JUMP:    state_d = ST_FETCH;
            ST_ILLEGAL: state_d = ST_INIT;
            default:    state_d = ST_INIT;
         endcase
      end else begin
         state_d = state_q;
         ir_d    = ir_q;
      end
   end

   // Per-state output decode, then strobe gating by ce and rst
   always_comb begin
      sel_adr_s    = 1'b0;
      mem_en_s     = 1'b0;
      mem_we_s     = 1'b0;
      load_pc_s    = 1'b0;
      enable_pc_s  = 1'b0;
      clear_pc_s   = 1'b0;
      load_ra_s    = 1'b0;
      sel_ual_s    = 1'b0;
      load_carry_s = 1'b0;
      init_carry_s = 1'b0;
      strobe_ok_s  = bus.ce & ~rst;
      case (state_q)
         ST_INIT: begin
            clear_pc_s   = 1'b1;
            enable_pc_s  = 1'b1;
            init_carry_s = 1'b1;
         end
         ST_FETCH: begin
            mem_en_s = 1'b1;
         end
         ST_DECODE: begin
            enable_pc_s = 1'b1;
         end
         ST_OPERAND: begin
            sel_adr_s = 1'b1;
            mem_en_s  = 1'b1;
         end
         ST_EXEC: begin
            // EXEC is only entered for ALU ops (IR[7]=0); IR[6] picks ADD
            load_ra_s    = ~ir_q[7];
            sel_ual_s    = ir_q[6];
            load_carry_s = ir_q[6];
         end
         ST_STORE: begin
            sel_adr_s = 1'b1;
            mem_en_s  = 1'b1;
            mem_we_s  = 1'b1;
         end
         ST_JUMP: begin
            // Jump taken on carry clear; a set carry is consumed instead
            load_pc_s    = ~bus.carry;
            init_carry_s = bus.carry;
         end
         ST_ILLEGAL: begin
            sel_adr_s = 1'b0;
         end
         default: begin
            sel_adr_s = 1'b0;
         end
      endcase
      if (rst) begin
         sel_adr_s = 1'b0;
         sel_ual_s = 1'b0;
      end else begin
         sel_adr_s = sel_adr_s;
         sel_ual_s = sel_ual_s;
      end
   end

   assign bus.sel_ADR    = sel_adr_s;
   assign bus.sel_UAL    = sel_ual_s;
   assign bus.mem_en     = mem_en_s     & strobe_ok_s;
   assign bus.mem_we     = mem_we_s     & strobe_ok_s;
   assign bus.load_PC    = load_pc_s    & strobe_ok_s;
   assign bus.enable_PC  = enable_pc_s  & strobe_ok_s;
   assign bus.clear_PC   = clear_pc_s   & strobe_ok_s;
   assign bus.load_RA    = load_ra_s    & strobe_ok_s;
   assign bus.load_carry = load_carry_s & strobe_ok_s;
   assign bus.init_carry = init_carry_s & strobe_ok_s;
   assign bus.state_dbg  = rst ? 3'd0 : state_q;
   assign bus.ir_addr    = rst ? 6'd0 : ir_q[5:0];

endmodule

// File: tb/tb_control_fsm.sv
// Testbench for control_fsm: directed vector table plus randomized run
// against a queue-based instruction-sequence model.
module tb_control_fsm;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   control_fsm_if ifc ();

   control_fsm dut (
      .clk (clk),
      .rst (rst),
      .bus (ifc)
   );

   // {sel_ADR, mem_en, mem_we, load_PC, enable_PC, clear_PC, load_RA, sel_UAL, load_carry, init_carry}
   logic [9:0] dut_ctl;
   assign dut_ctl = {ifc.sel_ADR, ifc.mem_en, ifc.mem_we, ifc.load_PC, ifc.enable_PC,
                     ifc.clear_PC, ifc.load_RA, ifc.sel_UAL, ifc.load_carry, ifc.init_carry};

   localparam logic [9:0] C_ZERO  = 10'b0000000000;
   localparam logic [9:0] C_INIT  = 10'b0000110001;
   localparam logic [9:0] C_FETCH = 10'b0100000000;
   localparam logic [9:0] C_DEC   = 10'b0000100000;
   localparam logic [9:0] C_OPER  = 10'b1100000000;
   localparam logic [9:0] C_ADD   = 10'b0000001110;
   localparam logic [9:0] C_NOR   = 10'b0000001000;
   localparam logic [9:0] C_STORE = 10'b1110000000;
   localparam logic [9:0] C_JMP0  = 10'b0001000000;
   localparam logic [9:0] C_JMP1  = 10'b0000000001;
   localparam logic [9:0] C_HOLD  = 10'b1000000100; // bits that survive ce=0

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic       r;
      logic       c;
      logic       cy;
      logic [7:0] in;
      logic [2:0] st;
      logic [5:0] ia;
      logic [9:0] ctl;
   } vec_t;

   vec_t tv[$];

   function automatic vec_t mk(logic r, logic c, logic cy, logic [7:0] in,
                               logic [2:0] st, logic [5:0] ia, logic [9:0] ctl);
      vec_t v;
      v.r = r; v.c = c; v.cy = cy; v.in = in; v.st = st; v.ia = ia; v.ctl = ctl;
      return v;
   endfunction

   task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h expected=%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic drive(logic r, logic c, logic [7:0] in, logic cy);
      rst          = r;
      ifc.ce       = c;
      ifc.instr_in = in;
      ifc.carry    = cy;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // ---------------- reference model ----------------
   // Current state number plus a queue of the states still owed by the
   // instruction in flight; an empty queue means the next step is a fetch.
   int         m_cur;
   int         m_q[$];
   logic [7:0] m_ir;

   function automatic logic [9:0] exp_ctl(int st, logic [7:0] ir, logic cy);
      case (st)
         0:       return C_INIT;
         1:       return C_FETCH;
         2:       return C_DEC;
         3:       return C_OPER;
         4:       return (ir[7:6] == 2'b01) ? C_ADD : C_NOR;
         5:       return C_STORE;
         6:       return cy ? C_JMP1 : C_JMP0;
         default: return C_ZERO;
      endcase
   endfunction

   task automatic model_reset();
      m_cur = 0;
      m_ir  = 8'h00;
      m_q.delete();
   endtask

   task automatic model_step(logic [7:0] in);
      if (m_cur == 2) begin
         m_ir = in;
         case (in[7:6])
            2'b00, 2'b01: begin m_q.push_back(3); m_q.push_back(4); end
            2'b10:        m_q.push_back(5);
            default:      m_q.push_back(6);
         endcase
      end
      if (m_q.size() > 0) begin
         m_cur = m_q.pop_front();
      end else begin
         m_cur = 1;
         m_q.push_back(2);
      end
   endtask

   initial begin
      // Directed table: each row is checked mid-cycle, then a clock edge follows
      tv.push_back(mk(1'b1, 1'b1, 1'b0, 8'h00, 3'd0, 6'd0,  C_ZERO));  // in reset
      tv.push_back(mk(1'b0, 1'b1, 1'b0, 8'hFF, 3'd0, 6'd0,  C_INIT));
      tv.push_back(mk(1'b0, 1'b1, 1'b0, 8'h45, 3'd1, 6'd0,  C_FETCH));
      tv.push_back(mk(1'b0, 1'b1, 1'b0, 8'h45, 3'd2, 6'd0,  C_DEC));
      tv.push_back(mk(1'b0, 1'b1, 1'b0, 8'hC0, 3'd3, 6'd5,  C_OPER));
      tv.push_back(mk(1'b0, 1'b1, 1'b1, 8'h80, 3'd4, 6'd5,  C_ADD));
      tv.push_back(mk(1'b0, 1'b1, 1'b0, 8'h0A, 3'd1, 6'd5,  C_FETCH));
      tv.push_back(mk(1'b0, 1'b1, 1'b0, 8'h0A, 3'd2, 6'd5,  C_DEC));
      tv.push_back(mk(1'b0, 1'b0, 1'b0, 8'hFF, 3'd3, 6'd10, C_OPER & C_HOLD)); // ce low x3
      tv.push_back(mk(1'b0, 1'b0, 1'b1, 8'h00, 3'd3, 6'd10, C_OPER & C_HOLD));
      tv.push_back(mk(1'b0, 1'b0, 1'b0, 8'h9F, 3'd3, 6'd10, C_OPER & C_HOLD));
      tv.push_back(mk(1'b0, 1'b1, 1'b0, 8'h9F, 3'd3, 6'd10, C_OPER));
      tv.push_back(mk(1'b0, 1'b1, 1'b1, 8'hFF, 3'd4, 6'd10, C_NOR));
      tv.push_back(mk(1'b0, 1'b1, 1'b0, 8'h9F, 3'd1, 6'd10, C_FETCH));
      tv.push_back(mk(1'b0, 1'b1, 1'b0, 8'h9F, 3'd2, 6'd10, C_DEC));
      tv.push_back(mk(1'b0, 1'b1, 1'b0, 8'h41, 3'd5, 6'd31, C_STORE));
      tv.push_back(mk(1'b0, 1'b1, 1'b0, 8'hC3, 3'd1, 6'd31, C_FETCH));
      tv.push_back(mk(1'b0, 1'b1, 1'b0, 8'hC3, 3'd2, 6'd31, C_DEC));
      tv.push_back(mk(1'b0, 1'b1, 1'b0, 8'h00, 3'd6, 6'd3,  C_JMP0));
      tv.push_back(mk(1'b0, 1'b1, 1'b1, 8'hC3, 3'd1, 6'd3,  C_FETCH));
      tv.push_back(mk(1'b0, 1'b1, 1'b1, 8'hC3, 3'd2, 6'd3,  C_DEC));
      tv.push_back(mk(1'b0, 1'b1, 1'b1, 8'h00, 3'd6, 6'd3,  C_JMP1));
      tv.push_back(mk(1'b0, 1'b1, 1'b0, 8'h45, 3'd1, 6'd3,  C_FETCH));
      tv.push_back(mk(1'b0, 1'b1, 1'b0, 8'h45, 3'd2, 6'd3,  C_DEC));
      tv.push_back(mk(1'b0, 1'b1, 1'b0, 8'h00, 3'd3, 6'd5,  C_OPER));
      tv.push_back(mk(1'b1, 1'b1, 1'b0, 8'h00, 3'd0, 6'd0,  C_ZERO));  // rst during EXEC
      tv.push_back(mk(1'b0, 1'b1, 1'b0, 8'h00, 3'd0, 6'd0,  C_INIT));
      tv.push_back(mk(1'b0, 1'b1, 1'b0, 8'h00, 3'd1, 6'd0,  C_FETCH));

      drive(1'b1, 1'b0, 8'h00, 1'b0);
      tick();
      tick();

      for (int i = 0; i < tv.size(); i++) begin
         drive(tv[i].r, tv[i].c, tv[i].in, tv[i].cy);
         #4;
         chk($sformatf("vec%0d_state", i), {29'd0, ifc.state_dbg}, {29'd0, tv[i].st});
         chk($sformatf("vec%0d_ir_addr", i), {26'd0, ifc.ir_addr}, {26'd0, tv[i].ia});
         chk($sformatf("vec%0d_ctl", i), {22'd0, dut_ctl}, {22'd0, tv[i].ctl});
         tick();
      end

      // Randomized run against the sequence model
      drive(1'b1, 1'b1, 8'($urandom), 1'($urandom));
      tick();
      model_reset();
      for (int n = 0; n < 3000; n++) begin
         logic       r, c, cy;
         logic [7:0] in;
         logic [2:0] e_st;
         logic [5:0] e_ia;
         logic [9:0] e_ctl;
         r  = ($urandom_range(0, 63) == 0);
         c  = ($urandom_range(0, 3) != 0);
         cy = 1'($urandom);
         in = 8'($urandom);
         drive(r, c, in, cy);
         #4;
         if (r) begin
            e_st  = 3'd0;
            e_ia  = 6'd0;
            e_ctl = C_ZERO;
         end else begin
            e_st  = 3'(m_cur);
            e_ia  = m_ir[5:0];
            e_ctl = exp_ctl(m_cur, m_ir, cy) & (c ? 10'h3FF : C_HOLD);
         end
         chk("rnd_state", {29'd0, ifc.state_dbg}, {29'd0, e_st});
         chk("rnd_ir_addr", {26'd0, ifc.ir_addr}, {26'd0, e_ia});
         chk("rnd_ctl", {22'd0, dut_ctl}, {22'd0, e_ctl});
         tick();
         if (r) begin
            model_reset();
         end else if (c) begin
            model_step(in);
         end
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
